// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the external memory port arbiter: FSM state
// encodings, default burst/starvation parameters and a width helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IFETCH  = 2'd1,
    S_DACCESS = 2'd2
  } state_e;

  localparam int LINEWORDS_DEF  = 4;
  localparam int STARVE_MAX_DEF = 3;

  // Starvation counter is never narrower than 2 bits.
  function automatic int starve_width(input int max_grants);
    return (max_grants < 4) ? 2 : $clog2(max_grants + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Grant decision between instruction refill and data access, with the
// saturating counter that bounds how long data traffic may starve fetch.
module arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic ph1,
  input  logic reset_b,
  input  logic ireq,
  input  logic dreq,
  input  logic en,
  input  logic commit,
  output logic grant_i,
  output logic grant_d
);

  localparam int SW = starve_width(STARVE_MAX);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  // NOTE: every variable gets its default before any branch, so no path through this block can infer a latch.
  always_comb begin
    grant_d  = en & dreq & (~ireq | (starve_q < SMAX));
    grant_i  = en & ireq & ~grant_d;
    starve_d = starve_q;
    if (commit) begin
      if (grant_i) begin
        starve_d = '0;
      end else if (grant_d && ireq && (starve_q < SMAX)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignment so the flop samples the value from before the edge.
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared external memory port: arbitrates instruction refill bursts against
// single-word data accesses and sequences the registered memory interface.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LINEWORDS  = LINEWORDS_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                         ph1,
  input  logic                         reset_b,
  input  logic                         ireq,
  input  logic [31:0]                  iadr,
  output logic [31:0]                  irdata,
  output logic                         ivalid,
  output logic [$clog2(LINEWORDS)-1:0] iword,
  output logic                         idone,
  input  logic                         dreq,
  input  logic                         dwrite,
  input  logic [31:0]                  dadr,
  input  logic [31:0]                  dwdata,
  input  logic [3:0]                   dbyteen,
  output logic [31:0]                  drdata,
  output logic                         ddone,
  output logic                         memreq,
  output logic [31:0]                  memadr,
  output logic [31:0]                  memwdata,
  output logic                         memwrite,
  output logic [3:0]                   membyteen,
  input  logic [31:0]                  memrdata,
  input  logic                         memready
);

  localparam int WB = $clog2(LINEWORDS);
  localparam int LB = WB + 2;
  localparam logic [WB-1:0] LAST_WORD = WB'(LINEWORDS - 1);

  state_e        state_q, state_d;
  logic [WB-1:0] wcnt_q, wcnt_d;
  logic          memreq_q, memreq_d;
  logic [31:0]   memadr_q, memadr_d;
  logic [31:0]   memwdata_q, memwdata_d;
  logic          memwrite_q, memwrite_d;
  logic [3:0]    membyteen_q, membyteen_d;
  logic [31:0]   drdata_q, drdata_d;
  logic          ddone_q, ddone_d;
  logic [31:0]   irdata_q, irdata_d;
  logic          ivalid_q, ivalid_d;
  logic [WB-1:0] iword_q, iword_d;
  logic          idone_q, idone_d;

  logic grant_i, grant_d, arb_en;
  logic unused_addr_bits;

  // Line offset and byte offset bits are address don't-cares.
  assign unused_addr_bits = ^{iadr[LB-1:0], dadr[1:0]};

  // The completion cycle doubles as the turnaround: no arbitration while a done pulse is out.
  assign arb_en = (state_q == S_IDLE) && !ddone_q && !idone_q;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb_pick (
    .ph1     (ph1),
    .reset_b (reset_b),
    .ireq    (ireq),
    .dreq    (dreq),
    .en      (arb_en),
    .commit  (arb_en),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    memreq_d    = memreq_q;
    memadr_d    = memadr_q;
    memwdata_d  = memwdata_q;
    memwrite_d  = memwrite_q;
    membyteen_d = membyteen_q;
    drdata_d    = drdata_q;
    irdata_d    = irdata_q;
    iword_d     = iword_q;
    ddone_d     = 1'b0;
    ivalid_d    = 1'b0;
    idone_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          state_d     = S_DACCESS;
          memreq_d    = 1'b1;
          memadr_d    = {dadr[31:2], 2'b00};
          memwdata_d  = dwdata;
          memwrite_d  = dwrite;
          membyteen_d = dwrite ? dbyteen : 4'hF;
        end else if (grant_i) begin
          state_d     = S_IFETCH;
          wcnt_d      = '0;
          memreq_d    = 1'b1;
          memadr_d    = {iadr[31:LB], {LB{1'b0}}};
          memwrite_d  = 1'b0;
          membyteen_d = 4'hF;
        end
      end

      S_DACCESS: begin
        if (memready) begin
          if (!memwrite_q) drdata_d = memrdata;
          ddone_d    = 1'b1;
          memreq_d   = 1'b0;
          memwrite_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_IFETCH: begin
        if (memready) begin
          irdata_d          = memrdata;
          iword_d           = wcnt_q;
          ivalid_d          = 1'b1;
          wcnt_d            = wcnt_q + 1'b1;
          memadr_d[LB-1:2]  = wcnt_q + 1'b1;
          if (wcnt_q == LAST_WORD) begin
            idone_d  = 1'b1;
            memreq_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        memreq_d = 1'b0;
      end
    endcase
  end

  // NOTE: data registers are reset along with control state because every output must read 0 during reset.
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      memreq_q    <= 1'b0;
      memadr_q    <= '0;
      memwdata_q  <= '0;
      memwrite_q  <= 1'b0;
      membyteen_q <= '0;
      drdata_q    <= '0;
      ddone_q     <= 1'b0;
      irdata_q    <= '0;
      ivalid_q    <= 1'b0;
      iword_q     <= '0;
      idone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      memreq_q    <= memreq_d;
      memadr_q    <= memadr_d;
      memwdata_q  <= memwdata_d;
      memwrite_q  <= memwrite_d;
      membyteen_q <= membyteen_d;
      drdata_q    <= drdata_d;
      ddone_q     <= ddone_d;
      irdata_q    <= irdata_d;
      ivalid_q    <= ivalid_d;
      iword_q     <= iword_d;
      idone_q     <= idone_d;
    end
  end

  assign memreq    = memreq_q;
  assign memadr    = memadr_q;
  assign memwdata  = memwdata_q;
  assign memwrite  = memwrite_q;
  assign membyteen = membyteen_q;
  assign drdata    = drdata_q;
  assign ddone     = ddone_q;
  assign irdata    = irdata_q;
  assign ivalid    = ivalid_q;
  assign iword     = iword_q;
  assign idone     = idone_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven data accesses,
// refill bursts, contention, reset mid-burst and turnaround, via scoreboards.
module tb_mem_port_arbiter;

  localparam int LW = 4;

  logic        ph1 = 1'b0;
  logic        reset_b = 1'b0;
  logic        ireq = 1'b0, dreq = 1'b0, dwrite = 1'b0, memready = 1'b0;
  logic [31:0] iadr = '0, dadr = '0, dwdata = '0, memrdata = '0;
  logic [3:0]  dbyteen = '0;
  logic [31:0] irdata, drdata, memadr, memwdata;
  logic [1:0]  iword;
  logic        ivalid, idone, ddone, memreq, memwrite;
  logic [3:0]  membyteen;

  mem_port_arbiter dut (
    .ph1(ph1), .reset_b(reset_b),
    .ireq(ireq), .iadr(iadr), .irdata(irdata), .ivalid(ivalid), .iword(iword), .idone(idone),
    .dreq(dreq), .dwrite(dwrite), .dadr(dadr), .dwdata(dwdata), .dbyteen(dbyteen),
    .drdata(drdata), .ddone(ddone),
    .memreq(memreq), .memadr(memadr), .memwdata(memwdata), .memwrite(memwrite),
    .membyteen(membyteen), .memrdata(memrdata), .memready(memready)
  );

  always #5 ph1 = ~ph1;

  typedef struct {
    logic        dwrite;
    logic [31:0] dadr;
    logic [31:0] dwdata;
    logic [3:0]  dbyteen;
    int          lat;
    logic [31:0] exp_adr;
    logic [3:0]  exp_be;
    logic [31:0] exp_drdata;
  } dvec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  word;
    logic        last;
  } iexp_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        write;
    logic [3:0]  be;
  } xfer_t;

  int errors = 0;
  int checks = 0;

  iexp_t       iq[$];
  logic [31:0] dq[$];
  xfer_t       xlog[$];
  bit          glog[$];
  int ddone_cnt = 0, ivalid_cnt = 0, idone_cnt = 0, memreq_rise = 0;

  int mem_lat = 0;
  bit spurious = 1'b0;
  int wait_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, detail);
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a + 32'd1;
  endfunction

  // Memory responder: drives memready a fixed number of cycles into each transfer.
  initial forever begin
    @(posedge ph1);
    #2;
    if (memreq) begin
      if (wait_cnt >= mem_lat) begin
        memready = 1'b1;
        memrdata = mem_model(memadr);
        wait_cnt = 0;
      end else begin
        memready = 1'b0;
        wait_cnt++;
      end
    end else begin
      memready = spurious;
      memrdata = 32'hDEAD_0000;
      wait_cnt = 0;
    end
  end

  // Monitor: scoreboard pops, completion timing, memory-side hold stability.
  xfer_t mon_snap, mon_cur;
  bit    mon_in_x = 1'b0, mon_prev_x = 1'b0, mon_prev_mr = 1'b0;
  iexp_t mon_ie;

  initial forever begin
    @(negedge ph1);
    if (!reset_b) begin
      mon_in_x = 1'b0; mon_prev_x = 1'b0; mon_prev_mr = 1'b0;
      continue;
    end
    if (mon_prev_x || ddone || ivalid)
      check("done_one_cycle_after_memready", 32'(ddone | ivalid), 32'(mon_prev_x));
    if (ddone) begin
      ddone_cnt++;
      glog.push_back(1'b0);
      if (dq.size() == 0) fail("ddone_unexpected", $sformatf("ddone with drdata=0x%08h, none expected", drdata));
      else check("drdata", drdata, dq.pop_front());
    end
    if (ivalid) begin
      ivalid_cnt++;
      if (iq.size() == 0) begin
        fail("ivalid_unexpected", $sformatf("ivalid word %0d, none expected", iword));
      end else begin
        mon_ie = iq.pop_front();
        check("irdata", irdata, mon_ie.data);
        check("iword", 32'(iword), 32'(mon_ie.word));
        check("idone", 32'(idone), 32'(mon_ie.last));
      end
      if (idone) begin
        idone_cnt++;
        glog.push_back(1'b1);
      end
    end else if (idone) begin
      fail("idone_without_ivalid", "idone=1 while ivalid=0, required ivalid=1");
    end
    if (memreq && !mon_prev_mr) memreq_rise++;
    if (memreq) begin
      mon_cur = '{adr: memadr, wdata: memwdata, write: memwrite, be: membyteen};
      if (mon_in_x) begin
        check("hold_memadr", mon_cur.adr, mon_snap.adr);
        check("hold_memwdata", mon_cur.wdata, mon_snap.wdata);
        check("hold_memwrite", 32'(mon_cur.write), 32'(mon_snap.write));
        check("hold_membyteen", 32'(mon_cur.be), 32'(mon_snap.be));
      end else begin
        mon_snap = mon_cur;
        mon_in_x = 1'b1;
      end
      if (memready) begin
        xlog.push_back(mon_cur);
        mon_in_x = 1'b0;
      end
    end else begin
      mon_in_x = 1'b0;
    end
    mon_prev_x  = memreq && memready;
    mon_prev_mr = memreq;
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_memadr"}, memadr, 32'h0);
    check({tag, "_memwdata"}, memwdata, 32'h0);
    check({tag, "_irdata"}, irdata, 32'h0);
    check({tag, "_drdata"}, drdata, 32'h0);
    check({tag, "_ctl"}, 32'({memreq, memwrite, membyteen, ivalid, iword, idone, ddone}), 32'h0);
  endtask

  task automatic data_access(input dvec_t v, input string tag);
    int    n0;
    xfer_t x;
    dwrite = v.dwrite; dadr = v.dadr; dwdata = v.dwdata; dbyteen = v.dbyteen;
    mem_lat = v.lat;
    dreq = 1'b1;
    dq.push_back(v.exp_drdata);
    n0 = ddone_cnt;
    tick();
    check({tag, "_grant_next_cycle"}, 32'(memreq), 32'h1);
    for (int k = 0; k < 50 && ddone_cnt == n0; k++) tick();
    if (ddone_cnt == n0) fail({tag, "_timeout"}, "no ddone within 50 cycles, required one");
    dreq = 1'b0;
    if (xlog.size() == 0) begin
      fail({tag, "_xfer"}, "no memory transfer seen, required one");
    end else begin
      x = xlog.pop_front();
      check({tag, "_memadr"}, x.adr, v.exp_adr);
      check({tag, "_memwrite"}, 32'(x.write), 32'(v.dwrite));
      check({tag, "_memwdata"}, x.wdata, v.dwdata);
      check({tag, "_membyteen"}, 32'(x.be), 32'(v.exp_be));
    end
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int k = 0; k < LW; k++)
      iq.push_back('{data: mem_model(base + 32'(4 * k)), word: 2'(k), last: (k == LW - 1)});
  endtask

  task automatic refill(input logic [31:0] adr, input logic [31:0] base, input int lat, input string tag);
    int    n0, r0;
    xfer_t x;
    push_line(base);
    iadr = adr; mem_lat = lat; ireq = 1'b1;
    n0 = idone_cnt;
    r0 = memreq_rise;
    tick();
    check({tag, "_grant_next_cycle"}, 32'(memreq), 32'h1);
    for (int k = 0; k < 100 && idone_cnt == n0; k++) tick();
    if (idone_cnt == n0) fail({tag, "_timeout"}, "no idone within 100 cycles, required one");
    ireq = 1'b0;
    check({tag, "_single_memreq_burst"}, 32'(memreq_rise - r0), 32'h1);
    for (int k = 0; k < LW; k++) begin
      if (xlog.size() == 0) begin
        fail({tag, "_xfer"}, $sformatf("word %0d transfer missing", k));
      end else begin
        x = xlog.pop_front();
        check($sformatf("%s_memadr_w%0d", tag, k), x.adr, base + 32'(4 * k));
        check($sformatf("%s_rdonly_w%0d", tag, k), 32'({x.write, x.be}), 32'h0000_000F);
      end
    end
  endtask

  dvec_t vecs[5];
  bit    exp_order[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int n0, r0, d0;

    vecs[0] = '{dwrite: 1'b0, dadr: 32'h0000_0014, dwdata: 32'h0,         dbyteen: 4'h0, lat: 2,
                exp_adr: 32'h0000_0014, exp_be: 4'hF, exp_drdata: 32'd21};
    vecs[1] = '{dwrite: 1'b1, dadr: 32'h0000_0204, dwdata: 32'd7,         dbyteen: 4'h3, lat: 3,
                exp_adr: 32'h0000_0204, exp_be: 4'h3, exp_drdata: 32'd21};
    vecs[2] = '{dwrite: 1'b0, dadr: 32'h0000_1003, dwdata: 32'h5555_5555, dbyteen: 4'h1, lat: 0,
                exp_adr: 32'h0000_1000, exp_be: 4'hF, exp_drdata: 32'h0000_1001};
    vecs[3] = '{dwrite: 1'b1, dadr: 32'hFFFF_FFFC, dwdata: 32'hDEAD_BEEF, dbyteen: 4'hC, lat: 1,
                exp_adr: 32'hFFFF_FFFC, exp_be: 4'hC, exp_drdata: 32'h0000_1001};
    vecs[4] = '{dwrite: 1'b0, dadr: 32'h8000_0010, dwdata: 32'h0,         dbyteen: 4'hF, lat: 1,
                exp_adr: 32'h8000_0010, exp_be: 4'hF, exp_drdata: 32'h8000_0011};
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    #3;
    check_outputs_zero("reset");
    #9 reset_b = 1'b1;
    tick();
    tick();
    check("idle_no_memreq", 32'(memreq), 32'h0);

    // Table-driven data reads and writes
    for (int i = 0; i < 5; i++) data_access(vecs[i], $sformatf("dvec%0d", i));
    tick();

    // Refill bursts
    refill(32'hBFC0_0008, 32'hBFC0_0000, 0, "refill_fast");
    tick();
    refill(32'h0001_FFF4, 32'h0001_FFF0, 2, "refill_slow");
    tick();

    // Contention: both requesters held, memory always ready
    xlog.delete();
    glog.delete();
    for (int k = 0; k < 6; k++) dq.push_back(32'h0000_0041);
    push_line(32'h0000_2000);
    push_line(32'h0000_2000);
    iadr = 32'h0000_2004; dadr = 32'h0000_0040; dwrite = 1'b0; dbyteen = 4'hF; mem_lat = 0;
    ireq = 1'b1; dreq = 1'b1;
    for (int k = 0; k < 200 && glog.size() < 8; k++) tick();
    ireq = 1'b0; dreq = 1'b0;
    if (glog.size() < 8) begin
      fail("contention_timeout", $sformatf("%0d grants completed, required 8", glog.size()));
    end else begin
      for (int k = 0; k < 8; k++)
        check($sformatf("contention_grant%0d_is_ifetch", k), 32'(glog[k]), 32'(exp_order[k]));
    end
    tick();
    xlog.delete();

    // Reset mid-burst, then restart from word 0 with ireq still held
    push_line(32'h0000_3000);
    iadr = 32'h0000_3008; mem_lat = 1; ireq = 1'b1;
    n0 = ivalid_cnt;
    for (int k = 0; k < 50 && ivalid_cnt < n0 + 2; k++) tick();
    check("rst_two_words_before_abort", 32'(ivalid_cnt - n0), 32'h2);
    reset_b = 1'b0;
    #1;
    check_outputs_zero("rst_mid_burst");
    iq.delete();
    xlog.delete();
    #1 reset_b = 1'b1;
    refill(32'h0000_3008, 32'h0000_3000, 1, "rst_restart");
    tick();

    // Turnaround: dreq held through ddone then dropped; stray memready while idle
    spurious = 1'b1;
    r0 = memreq_rise;
    d0 = ddone_cnt;
    data_access('{dwrite: 1'b0, dadr: 32'h0000_0080, dwdata: 32'h0, dbyteen: 4'hF, lat: 1,
                  exp_adr: 32'h0000_0080, exp_be: 4'hF, exp_drdata: 32'h0000_0081}, "turnaround");
    for (int k = 0; k < 6; k++) tick();
    check("turnaround_one_memreq", 32'(memreq_rise - r0), 32'h1);
    check("turnaround_one_ddone", 32'(ddone_cnt - d0), 32'h1);
    spurious = 1'b0;

    check("scoreboard_i_empty", 32'(iq.size()), 32'h0);
    check("scoreboard_d_empty", 32'(dq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
